pipe_mem_lsu: RTL and testbench
===============================

Name: pipe_mem_lsu

Overview:
- Memory-stage load/store unit that sits directly downstream of the EX/MEM pipeline register and consumes its *_M outputs.
- Runs data-memory accesses over a variable-latency req/ack bus, aligns and extends load data, and stalls the upstream pipeline while an access is outstanding.
- Drives registered results (*_W) to the writeback stage.

Parameters:
- TIMEOUT, 255, max cycles in REQ without ack before aborting with bus error (1..65535).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- reg_wr_M  in  1  instruction writes rd
- mem_wr_M  in  1  store
- mem_rd_M  in  1  load
- mem_mask_M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- sel_wb_M  in  2  writeback select, passed through
- alu_o_M  in  32  effective address / ALU result
- wr_data_M  in  32  store data (low bits significant)
- rd_M  in  5  destination register
- PC4_M  in  32  PC+4, passed through
- stall_mem  out  1  freeze upstream stages and EX/MEM register
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: {addr[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_ack  in  1  bus completion, sampled at posedge while dmem_req=1
- dmem_rdata  in  32  read word, valid with dmem_ack
- reg_wr_W, sel_wb_W, rd_W, alu_o_W, PC4_W  out  1/2/5/32/32  registered pass-through to WB
- rdata_W  out  32  aligned, extended load result
- misalign_o  out  1  one-cycle pulse: misaligned or illegal-size access
- bus_err_o  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including dmem_req, stall_mem and *_W.
- FSM states: IDLE, REQ, RESP.
  - IDLE, no memory op: *_W <= *_M next edge (1-cycle latency), rdata_W <= 0, stall_mem=0.
  - IDLE, aligned mem op: stall_mem=1 combinationally. Next edge: latch addr, size, data, rd, reg_wr, sel_wb, PC4; dmem_req <= 1; *_W <= bubble (reg_wr_W=0); go REQ.
  - REQ: stall_mem=1; bus outputs held stable; wait counter increments.
    - Edge with dmem_ack=1: capture extracted rdata; dmem_req <= 0; go RESP.
    - Counter reaches TIMEOUT with no ack: dmem_req <= 0; bus_err_o pulses in RESP; go RESP with error flag.
  - RESP: stall_mem=0. Next edge: *_W <= latched fields and rdata_W (reg_wr_W forced 0 on error, rdata_W=0 on error or store); go IDLE. The following instruction is accepted from IDLE on the same edge.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory op with ack on the first REQ cycle: 3 cycles total, stall_mem high 2 cycles.
- Alignment and lanes, off = addr[1:0]:
  - B: be = 0001<<off; wdata = {4{wd[7:0]}}.
  - H: be = 0011<<off; wdata = {2{wd[15:0]}}.
  - W: be = 1111; wdata = wd.
  - Loads with dmem_we=0 drive be per size.
- Load extract: B/H sign-extend and BU/HU zero-extend the lane at byte 8*off; W returns the full word.
- Misaligned (H with off[0]=1, W with off!=0) or illegal mask (011, 110, 111):
  - No bus request, no stall.
  - misalign_o pulses on the edge the instruction passes to WB; reg_wr_W=0 for it.
- mem_rd_M and mem_wr_M both 1: treated as store.
- dmem_ack while dmem_req=0: ignored.
- Upstream inputs are not sampled in REQ or RESP; only latched copies are used.
- Reset mid-REQ: dmem_req drops immediately (asynchronous); the pending access is abandoned and no WB write occurs.
- Wait counter width: clog2(TIMEOUT+1).

Test Plan:
- ALU op alu_o_M=0x1234, rd_M=5, reg_wr_M=1, no mem -> next cycle alu_o_W=0x1234, rd_W=5, reg_wr_W=1; stall_mem never asserted.
- LB addr 0x103, ack 1st REQ cycle with rdata 0x80FF_0000 -> dmem_addr=0x100, be=1000, rdata_W=0xFFFF_FF80; stall_mem high exactly 2 cycles.
- SH addr 0x202, wr_data 0xDEAD_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, reg_wr_W=0 after RESP.
- LW addr 0x101 -> no dmem_req, misalign_o=1 for 1 cycle, reg_wr_W=0, stall_mem=0.
- TIMEOUT=4, LW with ack never asserted -> dmem_req high 4 cycles then drops, bus_err_o pulse, reg_wr_W=0, pipeline resumes.
- LHU addr 0x002 with ack delayed 3 cycles; rst pulsed low during 2nd REQ cycle -> dmem_req and stall_mem drop same cycle, all *_W=0, state IDLE after rst release.

Source files
------------

// File: rtl/pipe_mem_lsu.sv
// Memory-stage load/store unit: runs data accesses over a req/ack bus, aligns
// and extends load data, stalls upstream while busy and registers results to WB.
module pipe_mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr_M,
  input  logic        mem_wr_M,
  input  logic        mem_rd_M,
  input  logic [2:0]  mem_mask_M,
  input  logic [1:0]  sel_wb_M,
  input  logic [31:0] alu_o_M,
  input  logic [31:0] wr_data_M,
  input  logic [4:0]  rd_M,
  input  logic [31:0] PC4_M,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        reg_wr_W,
  output logic [1:0]  sel_wb_W,
  output logic [4:0]  rd_W,
  output logic [31:0] alu_o_W,
  output logic [31:0] PC4_W,
  output logic [31:0] rdata_W,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  function automatic logic bad_access(input logic [2:0] mask, input logic [1:0] off);
    case (mask)
      3'b000:  return 1'b0;
      3'b001:  return off[0];
      3'b010:  return (off != 2'b00);
      3'b100:  return 1'b0;
      3'b101:  return off[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] mask, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (mask)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, sh[15:0]};
      default: return word;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, load_q, load_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, pc4_q, pc4_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  mask_q, mask_d;
  logic [1:0]  off_q, off_d, sel_q, sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_wr_w_q, reg_wr_w_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [1:0]  sel_w_q, sel_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] alu_w_q, alu_w_d, pc4_w_q, pc4_w_d, rdata_w_q, rdata_w_d;
  logic        mem_op_s, bad_s, stall_s;

  assign mem_op_s = mem_rd_M | mem_wr_M;
  assign bad_s    = bad_access(mem_mask_M, alu_o_M[1:0]);

  // Next-state, bus latch and writeback computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    load_d     = load_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    mask_d     = mask_q;
    off_d      = off_q;
    alu_d      = alu_q;
    pc4_d      = pc4_q;
    rdata_d    = rdata_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    reg_wr_d   = reg_wr_q;
    reg_wr_w_d = reg_wr_w_q;
    sel_w_d    = sel_w_q;
    rd_w_d     = rd_w_q;
    alu_w_d    = alu_w_q;
    pc4_w_d    = pc4_w_q;
    rdata_w_d  = rdata_w_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s && !bad_s) begin
          stall_s    = 1'b1;
          req_d      = 1'b1;
          we_d       = mem_wr_M;
          load_d     = ~mem_wr_M;
          err_d      = 1'b0;
          cnt_d      = '0;
          addr_d     = {alu_o_M[31:2], 2'b00};
          be_d       = lane_be(mem_mask_M[1:0], alu_o_M[1:0]);
          wdata_d    = lane_wdata(mem_mask_M[1:0], wr_data_M);
          mask_d     = mem_mask_M;
          off_d      = alu_o_M[1:0];
          alu_d      = alu_o_M;
          pc4_d      = PC4_M;
          sel_d      = sel_wb_M;
          rd_d       = rd_M;
          reg_wr_d   = reg_wr_M;
          rdata_d    = 32'h0000_0000;
          reg_wr_w_d = 1'b0;
          sel_w_d    = 2'b00;
          rd_w_d     = 5'd0;
          alu_w_d    = 32'h0000_0000;
          pc4_w_d    = 32'h0000_0000;
          rdata_w_d  = 32'h0000_0000;
          state_d    = REQ;
        end else begin
          // Misaligned/illegal accesses flow through as a non-writing instruction.
          reg_wr_w_d = reg_wr_M & ~mem_op_s;
          sel_w_d    = sel_wb_M;
          rd_w_d     = rd_M;
          alu_w_d    = alu_o_M;
          pc4_w_d    = PC4_M;
          rdata_w_d  = 32'h0000_0000;
          misalign_d = mem_op_s;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (dmem_ack) begin
          rdata_d = load_extract(mask_q, off_q, dmem_rdata);
          req_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        reg_wr_w_d = reg_wr_q & ~err_q;
        sel_w_d    = sel_q;
        rd_w_d     = rd_q;
        alu_w_d    = alu_q;
        pc4_w_d    = pc4_q;
        rdata_w_d  = (err_q || !load_q) ? 32'h0000_0000 : rdata_q;
        state_d    = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, bus and writeback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'b0000;
      mask_q     <= 3'b000;
      off_q      <= 2'b00;
      alu_q      <= 32'h0000_0000;
      pc4_q      <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      sel_q      <= 2'b00;
      rd_q       <= 5'd0;
      reg_wr_q   <= 1'b0;
      reg_wr_w_q <= 1'b0;
      sel_w_q    <= 2'b00;
      rd_w_q     <= 5'd0;
      alu_w_q    <= 32'h0000_0000;
      pc4_w_q    <= 32'h0000_0000;
      rdata_w_q  <= 32'h0000_0000;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      load_q     <= load_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      mask_q     <= mask_d;
      off_q      <= off_d;
      alu_q      <= alu_d;
      pc4_q      <= pc4_d;
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      reg_wr_q   <= reg_wr_d;
      reg_wr_w_q <= reg_wr_w_d;
      sel_w_q    <= sel_w_d;
      rd_w_q     <= rd_w_d;
      alu_w_q    <= alu_w_d;
      pc4_w_q    <= pc4_w_d;
      rdata_w_q  <= rdata_w_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Stall is combinational but must read 0 while reset is held.
  assign stall_mem  = rst & stall_s;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign reg_wr_W   = reg_wr_w_q;
  assign sel_wb_W   = sel_w_q;
  assign rd_W       = rd_w_q;
  assign alu_o_W    = alu_w_q;
  assign PC4_W      = pc4_w_q;
  assign rdata_W    = rdata_w_q;
  assign misalign_o = misalign_q;
  assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_pipe_mem_lsu.sv
// Directed bench for pipe_mem_lsu (TIMEOUT=4): ALU pass-through, loads, stores,
// misaligned/illegal accesses, ack timeout and reset during an access.
module tb_pipe_mem_lsu;
  logic        clk, rst;
  logic        reg_wr_M, mem_wr_M, mem_rd_M;
  logic [2:0]  mem_mask_M;
  logic [1:0]  sel_wb_M;
  logic [31:0] alu_o_M, wr_data_M, PC4_M;
  logic [4:0]  rd_M;
  logic        stall_mem, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        reg_wr_W, misalign_o, bus_err_o;
  logic [1:0]  sel_wb_W;
  logic [4:0]  rd_W;
  logic [31:0] alu_o_W, PC4_W, rdata_W;
  int total = 0;
  int bad = 0;

  pipe_mem_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .reg_wr_M(reg_wr_M), .mem_wr_M(mem_wr_M), .mem_rd_M(mem_rd_M),
    .mem_mask_M(mem_mask_M), .sel_wb_M(sel_wb_M), .alu_o_M(alu_o_M), .wr_data_M(wr_data_M),
    .rd_M(rd_M), .PC4_M(PC4_M), .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .reg_wr_W(reg_wr_W), .sel_wb_W(sel_wb_W), .rd_W(rd_W),
    .alu_o_W(alu_o_W), .PC4_W(PC4_W), .rdata_W(rdata_W), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic wr, input logic rdm, input logic [2:0] mask,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    reg_wr_M = rw; mem_wr_M = wr; mem_rd_M = rdm; mem_mask_M = mask;
    alu_o_M = a; wr_data_M = wd; rd_M = rd; sel_wb_M = 2'b01; PC4_M = a + 32'd4;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  // Load with ack on the first REQ cycle; checks the extended result.
  task automatic load_ack1(input string tag, input logic [2:0] mask, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b1, mask, a, 32'h0, 5'd11);
    tick();
    dmem_ack = 1'b1; dmem_rdata = word;
    tick();
    dmem_ack = 1'b0;
    tick();
    chk(tag, rdata_W, exp);
    nop();
  endtask

  initial begin
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    nop();
    tick();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_alu_w", alu_o_W, 32'h0);
    chk("rst_regwr_w", {31'd0, reg_wr_W}, 32'd0);
    rst = 1'b1;

    // ALU instruction, 1-cycle pass-through
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    #1 chk("alu_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("alu_alu_w", alu_o_W, 32'h0000_1234);
    chk("alu_rd_w", {27'd0, rd_W}, 32'd5);
    chk("alu_regwr_w", {31'd0, reg_wr_W}, 32'd1);
    chk("alu_pc4_w", PC4_W, 32'h0000_1238);
    chk("alu_stall2", {31'd0, stall_mem}, 32'd0);

    // LB 0x103, ack on first REQ cycle
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
    #1 chk("lb_stall_idle", {31'd0, stall_mem}, 32'd1);
    tick();
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_be", {28'd0, dmem_be}, 32'h8);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_stall_req", {31'd0, stall_mem}, 32'd1);
    chk("lb_bubble", {31'd0, reg_wr_W}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("lb_stall_resp", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("lb_rdata_w", rdata_W, 32'hFFFF_FF80);
    chk("lb_regwr_w", {31'd0, reg_wr_W}, 32'd1);
    chk("lb_rd_w", {27'd0, rd_W}, 32'd7);
    chk("lb_alu_w", alu_o_W, 32'h0000_0103);
    chk("lb_pc4_w", PC4_W, 32'h0000_0107);
    chk("lb_sel_w", {30'd0, sel_wb_W}, 32'd1);
    chk("lb_no_reissue", {31'd0, dmem_req}, 32'd0);
    nop();
    #1 chk("lb_stall_after", {31'd0, stall_mem}, 32'd0);

    // SH 0x202 with both rd/wr set (store), ack after one wait cycle
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0);
    tick();
    chk("sh_we", {31'd0, dmem_we}, 32'd1);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    tick();
    chk("sh_req_wait", {31'd0, dmem_req}, 32'd1);
    chk("sh_stall_wait", {31'd0, stall_mem}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    tick();
    chk("sh_regwr_w", {31'd0, reg_wr_W}, 32'd0);
    chk("sh_rdata_w", rdata_W, 32'h0);
    chk("sh_alu_w", alu_o_W, 32'h0000_0202);
    nop();

    // LW 0x101 misaligned
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd3);
    #1 chk("lw_mis_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("lw_mis_regwr", {31'd0, reg_wr_W}, 32'd0);
    chk("lw_mis_alu_w", alu_o_W, 32'h0000_0101);
    nop();
    tick();
    chk("lw_mis_pulse_end", {31'd0, misalign_o}, 32'd0);

    // Illegal mask 011 at an aligned address
    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 5'd3);
    tick();
    chk("ill_pulse", {31'd0, misalign_o}, 32'd1);
    chk("ill_req", {31'd0, dmem_req}, 32'd0);
    nop();
    tick();

    // LW 0x300 without ack: 4 REQ cycles then timeout
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd9);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_req_%0d", i), {31'd0, dmem_req}, 32'd1);
    end
    tick();
    chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to_bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("to_stall_resp", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("to_regwr_w", {31'd0, reg_wr_W}, 32'd0);
    chk("to_bus_err_end", {31'd0, bus_err_o}, 32'd0);
    chk("to_rdata_w", rdata_W, 32'h0);
    // pipeline resumes; stray ack while idle is ignored
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0ABC, 32'h0, 5'd12);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("resume_alu_w", alu_o_W, 32'h0000_0ABC);
    chk("resume_regwr_w", {31'd0, reg_wr_W}, 32'd1);
    chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
    nop();

    // More extraction cases
    load_ack1("lhu_rdata", 3'b101, 32'h0000_0002, 32'h8001_1234, 32'h0000_8001);
    load_ack1("lh_rdata", 3'b001, 32'h0000_0002, 32'h8001_1234, 32'hFFFF_8001);
    load_ack1("lbu_rdata", 3'b100, 32'h0000_0101, 32'h0000_F000, 32'h0000_00F0);
    load_ack1("lw_rdata", 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // LHU 0x002, reset during second REQ cycle
    drive(1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0002, 32'h0, 5'd4);
    tick();
    chk("rr_req1", {31'd0, dmem_req}, 32'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rr_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rr_stall_drop", {31'd0, stall_mem}, 32'd0);
    chk("rr_regwr_w", {31'd0, reg_wr_W}, 32'd0);
    chk("rr_alu_w", alu_o_W, 32'h0);
    chk("rr_rd_w", {27'd0, rd_W}, 32'd0);
    nop();
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0777, 32'h0, 5'd6);
    #1 chk("rr_idle_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("rr_idle_alu_w", alu_o_W, 32'h0000_0777);
    chk("rr_idle_req", {31'd0, dmem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
